// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one SEG-bit slice per stage, each slice built from rippled
// 4-bit carry-lookahead groups. Define CLA_PIPE_SUB_EN to compile in subtract mode (sub input).
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N      = WIDTH / SEG;
  localparam int GROUPS = SEG / 4;

  // Returns {carry into slice MSB, carry out of slice, slice sum}.
  function automatic logic [SEG+1:0] seg_add(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           cin
  );
    logic [SEG-1:0] s;
    logic           c;
    logic           c_msb;
    logic [3:0]     g;
    logic [3:0]     p;
    logic [4:0]     cc;
    s     = '0;
    c     = cin;
    c_msb = 1'b0;
    for (int j = 0; j < GROUPS; j++) begin
      g     = a[j*4 +: 4] & b[j*4 +: 4];
      p     = a[j*4 +: 4] ^ b[j*4 +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      s[j*4 +: 4] = p ^ cc[3:0];
      c_msb       = cc[3];
      c           = cc[4];
    end
    return {c_msb, c, s};
  endfunction

  logic [WIDTH-1:0] eff_b;
  logic             carry0;

`ifdef CLA_PIPE_SUB_EN
  assign eff_b  = sub ? ~operand2 : operand2;
  assign carry0 = carry_in ^ sub;
`else
  logic unused_sub;
  assign eff_b      = operand2;
  assign carry0     = carry_in;
  assign unused_sub = sub;
`endif

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Per-stage pipeline state; operands travel alongside the partial sum so every
  // field of a transaction leaves the last stage on the same cycle.
  logic             valid_pipe [N];
  logic [WIDTH-1:0] a_pipe     [N];
  logic [WIDTH-1:0] b_pipe     [N];
  logic [WIDTH-1:0] sum_pipe   [N];
  logic             carry_pipe [N];
  logic             ovf_pipe   [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : stage
      logic [WIDTH-1:0] st_a;
      logic [WIDTH-1:0] st_b;
      logic [WIDTH-1:0] st_sum_prev;
      logic [WIDTH-1:0] st_sum_next;
      logic             st_c;
      logic             st_v;
      logic [SEG+1:0]   st_r;
      logic             unused_bits;

      if (gi == 0) begin : g_first
        assign st_a        = operand1;
        assign st_b        = eff_b;
        assign st_c        = carry0;
        assign st_v        = in_valid;
        assign st_sum_prev = '0;
      end else begin : g_next
        assign st_a        = a_pipe[gi-1];
        assign st_b        = b_pipe[gi-1];
        assign st_c        = carry_pipe[gi-1];
        assign st_v        = valid_pipe[gi-1];
        assign st_sum_prev = sum_pipe[gi-1];
      end

      assign st_r = seg_add(st_a[gi*SEG +: SEG], st_b[gi*SEG +: SEG], st_c);

      always_comb begin
        st_sum_next                 = st_sum_prev;
        st_sum_next[gi*SEG +: SEG]  = st_r[SEG-1:0];
      end

      // Operand bits below the current slice, and the MSB-carry of inner slices, are dead.
      assign unused_bits = ^{st_a, st_b, a_pipe[gi], b_pipe[gi], ovf_pipe[gi], st_r[SEG+1]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_pipe[gi] <= 1'b0;
          a_pipe[gi]     <= '0;
          b_pipe[gi]     <= '0;
          sum_pipe[gi]   <= '0;
          carry_pipe[gi] <= 1'b0;
          ovf_pipe[gi]   <= 1'b0;
        end else if (!stall) begin
          valid_pipe[gi] <= st_v;
          a_pipe[gi]     <= st_a;
          b_pipe[gi]     <= st_b;
          sum_pipe[gi]   <= st_sum_next;
          carry_pipe[gi] <= st_r[SEG];
          ovf_pipe[gi]   <= st_r[SEG+1] ^ st_r[SEG];
        end
      end
    end
  endgenerate

  assign result    = sum_pipe[N-1];
  assign carry_out = carry_pipe[N-1];
  assign overflow  = ovf_pipe[N-1];
  assign out_valid = valid_pipe[N-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, SEG=8): driver pushes reference results,
// monitor pops and compares on every output transfer.
module tb_cla_pipe_adder;
  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int N     = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] operand1, operand2;
  logic             carry_in, sub, in_valid, in_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out, overflow, out_valid, out_ready;

  cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2),
    .carry_in(carry_in), .sub(sub), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          acc_cycle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;
  logic exact_lat = 1'b1;
  logic mon_en    = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] held_res;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain signed/unsigned arithmetic on the true operands.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sb);
    exp_t   e;
    longint ua, ub, sa, sbv, c, us, ss;
    logic   do_sub;
`ifdef CLA_PIPE_SUB_EN
    do_sub = sb;
`else
    do_sub = 1'b0;
`endif
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    c   = cin ? 1 : 0;
    if (!do_sub) begin
      us   = ua + ub + c;
      ss   = sa + sbv + c;
      e.co = us[32];
    end else begin
      us   = ua - ub - c;
      ss   = sa - sbv - c;
      e.co = (us >= 0);
    end
    e.res = us[31:0];
    e.ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    e.acc_cycle = 0;
    return e;
  endfunction

  // Accept side: every input transfer pushes its expected response.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e = ref_model(operand1, operand2, carry_in, sub);
      e.acc_cycle = cycle;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares on output transfers, checks hold during stall and in_ready.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", {32'd0, result}, {32'd0, held_res});
      end
      check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", {32'd0, result}, 64'd0 - 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("carry_out", {63'd0, carry_out}, {63'd0, e.co});
          check("overflow", {63'd0, overflow}, {63'd0, e.ov});
          if (exact_lat) check("latency", 64'(cycle - e.acc_cycle), 64'(N));
        end
      end
      prev_stall = out_valid && !out_ready;
      held_res   = result;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction and hold it until it is accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
    logic acc;
    int   n;
    operand1 = a; operand2 = b; carry_in = cin; sub = sb; in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; operand1 = '0; operand2 = '0; carry_in = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed corner vectors, unstalled, exact latency.
    exact_lat = 1'b1;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    in_valid = 1'b0; step(); step(); step(); step(); step();
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b1, 1'b0);
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    // Eight back-to-back with out_ready held high.
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'(i), 1'(i >> 1));
    in_valid = 1'b0;
    drain();

    // Eight back-to-back with a 3-cycle output stall mid-stream.
    exact_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (6) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      operand1  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      operand2  = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      carry_in  = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with three transactions in flight (held by a stall).
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h11111111 * (i + 1), 32'h01010101, 1'b0, 1'b0);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
    end
    check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_result", {32'd0, result}, 64'd0);
    check("async_rst_carry", {63'd0, carry_out}, 64'd0);
    check("async_rst_ovf", {63'd0, overflow}, 64'd0);
    check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    exact_lat = 1'b1;
    repeat (6) step();
    send(32'h12345678, 32'h87654321, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end
endmodule
